// File: rtl/logic_unit_arbiter_pkg.sv
// Shared opcodes and FSM encodings for the round-robin logic-unit arbiter.
package logic_unit_arbiter_pkg;
  localparam logic [2:0] OP_OR   = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/logic_unit_arbiter_logic_unit.sv
// Combinational six-function bitwise unit; opcodes 6/7 yield zero with err set.
module logic_unit
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             err
);
  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_NAND: y = ~(a & b);
      OP_XNOR: y = ~(a ^ b);
      default: err = 1'b1;
    endcase
  end
endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_unit between N_REQ requesters,
// with a three-state accept / execute / respond handshake.
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [3*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [1:0]             rsp_id,
  output logic                   rsp_err
);
  localparam int ID_W = 2;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  rr_ptr, win;
  logic             any_vld, accept;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [ID_W-1:0]  id_q;
  logic [WIDTH-1:0] lu_y;
  logic             lu_err;

  // Walk from the far end back toward rr_ptr so the closest valid requester wins.
  always_comb begin
    win     = '0;
    any_vld = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[rr_ptr + ID_W'(k)]) begin
        win     = rr_ptr + ID_W'(k);
        any_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: if (any_vld && !rst) begin
        req_ready[win] = 1'b1;
        accept         = 1'b1;
        state_nxt      = ST_EXEC;
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  logic_unit #(.WIDTH(WIDTH)) u_lu (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .y   (lu_y),
    .err (lu_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= req_op[3*win +: 3];
        a_q  <= req_a[WIDTH*win +: WIDTH];
        b_q  <= req_b[WIDTH*win +: WIDTH];
        id_q <= win;
      end
      if (state == ST_EXEC) begin
        rsp_data  <= lu_y;
        rsp_err   <= lu_err;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end
      // rsp_data/id/err are left untouched so they persist after the handshake.
      if (state == ST_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        rr_ptr    <= rsp_id + ID_W'(1);
      end
    end
  end
endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one WIDTH-bit six-function logic unit (OR, AND, XOR, NOR, NAND, XNOR) between N_REQ requesters.
- Round-robin arbitration picks a requester, latches its operands and opcode, evaluates the result and returns it with a valid/ready handshake.
- Sits between the gate datapath and the client blocks that need bitwise operations.

Parameters:
- WIDTH, 8, operand/result bit width.
- N_REQ, 4, number of requesters; fixed at 4 for this revision (rsp_id is 2 bits).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester accept; at most one bit high.
- req_op  input  3*N_REQ  opcode per requester; slice i = [3i+2:3i].
- req_a  input  WIDTH*N_REQ  operand A per requester; slice i = [WIDTH*i+WIDTH-1:WIDTH*i].
- req_b  input  WIDTH*N_REQ  operand B per requester; same slicing as req_a.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  WIDTH  result.
- rsp_id  output  2  index of the requester that owns the result.
- rsp_err  output  1  illegal opcode flag.

Behaviour:
- Reset (async, immediate):
  - state = IDLE, rr_ptr = 0.
  - req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0, rsp_err = 0.
  - Any in-flight transaction is discarded silently. The first grant after reset favours requester 0.
- Opcodes:
  - 0 = a|b, 1 = a&b, 2 = a^b, 3 = ~(a|b), 4 = ~(a&b), 5 = ~(a^b).
  - 6 and 7 are illegal: rsp_data = 0, rsp_err = 1.
- Arbitration:
  - Round-robin. Search order starts at rr_ptr: rr_ptr, rr_ptr+1, ... mod N_REQ.
  - The first requester with req_valid high wins.
- Handshake in:
  - In IDLE, req_ready[winner] is asserted combinationally in the same cycle. All other req_ready bits are 0.
  - Transfer happens when req_valid & req_ready are both high.
  - A requester must hold valid, op, a and b stable until accepted. Deasserting valid before acceptance withdraws the request with no side effect.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if any req_valid → accept winner, latch op/a/b/id, go to EXEC. Otherwise stay in IDLE.
  - EXEC: register the logic-unit result into rsp_data/rsp_err, set rsp_id, set rsp_valid = 1, go to RESP.
  - RESP: hold rsp_* stable while rsp_ready = 0. When rsp_ready = 1: clear rsp_valid, set rr_ptr = rsp_id+1 (mod N_REQ, wraps 3→0), go to IDLE.
  - req_ready = 0 throughout EXEC and RESP.
- Timing:
  - Latency: accept at edge T → rsp_valid high after edge T+1.
  - Back-to-back throughput with rsp_ready tied high is one transaction per 3 cycles.
  - rsp_data, rsp_id and rsp_err keep their last values after rsp_valid drops.
- Boundary cases:
  - All four requesters valid: grants follow 0,1,2,3,0,...
  - A single requester alone is re-granted on every IDLE pass.
  - A new req_valid arriving during EXEC/RESP waits; it is not lost or reordered.
  - rsp_ready high before rsp_valid has no effect.

Decomposition:
- Shared package holds:
  - opcode localparams OP_OR=0, OP_AND=1, OP_XOR=2, OP_NOR=3, OP_NAND=4, OP_XNOR=5;
  - state encodings ST_IDLE=0, ST_EXEC=1, ST_RESP=2.
- One sub-module, logic_unit: purely combinational, WIDTH parameter, inputs op/a/b, outputs y/err.
- The arbiter, FSM and response registers live in logic_unit_arbiter.

Test Plan:
- Reset mid-RESP (rsp_valid=1, rsp_ready=0), assert rst → all outputs 0 immediately. After release, a requester-3 request with op=1 is granted, and rsp_id=3 follows.
- Requester 0 only, a=8'hF0, b=8'h3C, ops 0..5 sequentially, rsp_ready=1 → rsp_data 8'hFC, 8'h30, 8'hCC, 8'h03, 8'hCF, 8'h33; rsp_err=0; each rsp_valid is 2 cycles after acceptance.
- All four valid continuously, distinct operands, rsp_ready=1 → rsp_id sequence 0,1,2,3,0,1,2,3. No requester is granted twice before the others.
- op=6 and op=7 from requester 2 → rsp_data=8'h00, rsp_err=1, rsp_id=2. A following op=2 gives rsp_err=0.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_* stable, all req_ready=0, FSM stays in RESP. rsp_ready=1 → one handshake, then the next grant.
- Withdrawal: requester 1 asserts valid with requester 0 granted; requester 1 drops valid during EXEC → no response ever carries rsp_id=1.
